add_nnbit_ahead_pipe: RTL and testbench

Pipelined, parametrised adder/subtractor built from 4-bit carry-lookahead groups. Each pipeline stage adds one STAGE_WIDTH slice and registers the inter-stage carry. Operands and results are skewed and deskewed so one operation can be accepted per cycle. Sits in the calc/add datapath and uses valid/ready handshaking on both sides, with full backpressure.

---
 rtl/add_pkg.sv | 19 +
 rtl/add_04bit_ahead.sv | 28 ++
 rtl/add_pipe_stage.sv | 33 +++
 rtl/add_nnbit_ahead_pipe.sv | 145 ++++++++++++++
 tb/tb_add_nnbit_ahead_pipe.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared constants, flag bundle and parameter check for the pipelined adder.
package add_pkg;

    localparam int unsigned ADD_GROUP_WIDTH = 4;

    typedef struct packed {
        logic cry;
        logic ovf;
        logic zero;
    } add_flags_t;

    // True when the stage width is a whole number of lookahead groups and
    // the data width is a whole number of stages.
    function automatic bit add_params_ok(input int unsigned data_w, input int unsigned stage_w);
        return (stage_w != 0) && (data_w != 0) &&
               ((stage_w % ADD_GROUP_WIDTH) == 0) && ((data_w % stage_w) == 0);
    endfunction

endpackage

// File: rtl/add_04bit_ahead.sv
// 4-bit carry-lookahead adder cell; all carries computed from generate/propagate.
module add_04bit_ahead (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Flat lookahead equations for all four internal carries.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
               (p[3] & p[2] & p[1] & p[0] & c[0]);
        s_o  = p ^ c[3:0];
        c_o  = c[4];
    end

endmodule

// File: rtl/add_pipe_stage.sv
// One pipeline slice: a ripple of 4-bit lookahead groups. Purely combinational;
// the enclosing pipeline owns every register.
module add_pipe_stage
    import add_pkg::*;
#(
    parameter int unsigned STAGE_WIDTH = 8
) (
    input  logic [STAGE_WIDTH-1:0] a_i,
    input  logic [STAGE_WIDTH-1:0] b_i,
    input  logic                   c_i,
    output logic [STAGE_WIDTH-1:0] sum_o,
    output logic                   c_o
);

    localparam int unsigned NUM_GROUPS = STAGE_WIDTH / ADD_GROUP_WIDTH;

    logic [NUM_GROUPS:0] gc;

    assign gc[0] = c_i;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        add_04bit_ahead u_cla (
            .a_i (a_i[g*ADD_GROUP_WIDTH +: ADD_GROUP_WIDTH]),
            .b_i (b_i[g*ADD_GROUP_WIDTH +: ADD_GROUP_WIDTH]),
            .c_i (gc[g]),
            .s_o (sum_o[g*ADD_GROUP_WIDTH +: ADD_GROUP_WIDTH]),
            .c_o (gc[g+1])
        );
    end

    assign c_o = gc[NUM_GROUPS];

endmodule

// File: rtl/add_nnbit_ahead_pipe.sv
// Pipelined add/subtract: one STAGE_WIDTH slice per stage, skewed operands,
// deskewed result, global advance enable with valid/ready on both sides.
module add_nnbit_ahead_pipe
    import add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STAGE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_ovf,
    output logic                  o_zero
);

    localparam int unsigned NUM_STAGES = DATA_WIDTH / STAGE_WIDTH;
    localparam int unsigned MSB        = STAGE_WIDTH - 1;

    if (!add_params_ok(DATA_WIDTH, STAGE_WIDTH)) begin : g_param_err
        $error("add_nnbit_ahead_pipe: DATA_WIDTH must be a multiple of STAGE_WIDTH, STAGE_WIDTH a multiple of 4");
    end

    logic                  en;
    logic                  v_last;
    logic [DATA_WIDTH-1:0] b_eff;
    logic                  cin;

    // Subtraction is a + ~b + 1; the external carry only matters when adding.
    assign b_eff = i_sub ? ~i_num_b : i_num_b;
    assign cin   = i_sub | i_cry;

    // The whole pipe moves when the last stage is empty or being drained.
    assign en      = ~v_last | i_ready;
    assign o_ready = en;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when entering this stage.
        localparam int unsigned IN_W  = DATA_WIDTH - k * STAGE_WIDTH;
        // Result bits known after this stage.
        localparam int unsigned RES_W = (k + 1) * STAGE_WIDTH;

        logic [IN_W-1:0]        a_in;
        logic [IN_W-1:0]        b_in;
        logic                   c_in;
        logic                   v_in;
        logic [STAGE_WIDTH-1:0] sum;
        logic                   cout;
        logic [RES_W-1:0]       res_d;
        logic [RES_W-1:0]       res_q;
        logic                   v_q;

        if (k == 0) begin : g_first
            assign a_in  = i_num_a;
            assign b_in  = b_eff;
            assign c_in  = cin;
            assign v_in  = i_valid;
            assign res_d = sum;
        end else begin : g_next
            assign a_in  = g_stage[k-1].g_hold.a_q;
            assign b_in  = g_stage[k-1].g_hold.b_q;
            assign c_in  = g_stage[k-1].g_hold.cry_q;
            assign v_in  = g_stage[k-1].v_q;
            assign res_d = {sum, g_stage[k-1].res_q};
        end

        add_pipe_stage #(
            .STAGE_WIDTH (STAGE_WIDTH)
        ) u_stage (
            .a_i   (a_in[STAGE_WIDTH-1:0]),
            .b_i   (b_in[STAGE_WIDTH-1:0]),
            .c_i   (c_in),
            .sum_o (sum),
            .c_o   (cout)
        );

        // Valid bit and accumulated result slices advance on the global enable.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q   <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                v_q   <= v_in;
                res_q <= res_d;
            end
        end

        if (k < NUM_STAGES - 1) begin : g_hold
            localparam int unsigned HI_W = IN_W - STAGE_WIDTH;

            logic [HI_W-1:0] a_q;
            logic [HI_W-1:0] b_q;
            logic            cry_q;

            // Delay the still-unused operand slices and pass the slice carry on.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    cry_q <= 1'b0;
                end else if (en) begin
                    a_q   <= a_in[IN_W-1:STAGE_WIDTH];
                    b_q   <= b_in[IN_W-1:STAGE_WIDTH];
                    cry_q <= cout;
                end
            end
        end else begin : g_last
            add_flags_t flags_d;
            add_flags_t flags_q;

            // Overflow: carry into the MSB (recovered from a^b'^sum) differs from carry out.
            always_comb begin
                flags_d      = '0;
                flags_d.cry  = cout;
                flags_d.ovf  = (a_in[MSB] ^ b_in[MSB] ^ sum[MSB]) ^ cout;
                flags_d.zero = ~|res_d;
            end

            // Output flags register alongside the final result slice.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    flags_q <= '0;
                end else if (en) begin
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign v_last  = g_stage[NUM_STAGES-1].v_q;
    assign o_valid = v_last;
    assign o_res   = g_stage[NUM_STAGES-1].res_q;
    assign o_cry   = g_stage[NUM_STAGES-1].g_last.flags_q.cry;
    assign o_ovf   = g_stage[NUM_STAGES-1].g_last.flags_q.ovf;
    assign o_zero  = g_stage[NUM_STAGES-1].g_last.flags_q.zero;

endmodule

// File: tb/tb_add_nnbit_ahead_pipe.sv
// Bench for add_nnbit_ahead_pipe: a 4-stage default instance and a 1-stage instance,
// both checked against a plain-arithmetic reference model.
module tb_add_nnbit_ahead_pipe;

    typedef struct {
        logic [31:0] res;
        logic        cry;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        valid0, ordy0, cry0, sub0, ovld0, rdy0, ocry0, oovf0, ozero0;
    logic [31:0] a0, b0, res0;
    logic        valid1, ordy1, cry1, sub1, ovld1, rdy1, ocry1, oovf1, ozero1;
    logic [31:0] a1, b1, res1;

    int n_checks = 0;
    int n_fail   = 0;

    add_nnbit_ahead_pipe #(.DATA_WIDTH(32), .STAGE_WIDTH(8)) dut (
        .i_clk   (clk),    .i_rst_n (rst_n),
        .i_valid (valid0), .o_ready (ordy0),
        .i_num_a (a0),     .i_num_b (b0),
        .i_cry   (cry0),   .i_sub   (sub0),
        .o_valid (ovld0),  .i_ready (rdy0),
        .o_res   (res0),   .o_cry   (ocry0),
        .o_ovf   (oovf0),  .o_zero  (ozero0)
    );

    add_nnbit_ahead_pipe #(.DATA_WIDTH(32), .STAGE_WIDTH(32)) dut1 (
        .i_clk   (clk),    .i_rst_n (rst_n),
        .i_valid (valid1), .o_ready (ordy1),
        .i_num_a (a1),     .i_num_b (b1),
        .i_cry   (cry1),   .i_sub   (sub1),
        .o_valid (ovld1),  .i_ready (rdy1),
        .o_res   (res1),   .o_cry   (ocry1),
        .o_ovf   (oovf1),  .o_zero  (ozero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision sum, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cy, input logic sub);
        exp_t        e;
        logic [31:0] bp;
        logic [32:0] s;
        bp     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bp} + 33'(sub ? 1'b1 : cy);
        e.res  = s[31:0];
        e.cry  = s[32];
        e.ovf  = (a[31] == bp[31]) && (e.res[31] != a[31]);
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single isolated operation: measures latency and checks result and flags.
    task automatic run_single(input bit d1, input string tag, input logic [31:0] a,
                              input logic [31:0] b, input logic cy, input logic sub);
        exp_t e;
        int   edges;
        int   lat_exp;
        logic ov;
        e       = model(a, b, cy, sub);
        lat_exp = d1 ? 1 : 4;
        if (d1) begin valid1 = 1'b1; a1 = a; b1 = b; cry1 = cy; sub1 = sub; end
        else    begin valid0 = 1'b1; a0 = a; b0 = b; cry0 = cy; sub0 = sub; end
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin valid0 = 1'b0; valid1 = 1'b0; end
            ov = d1 ? ovld1 : ovld0;
        end while (!ov && edges < 12);
        check({tag, " valid"},   32'(ov), 32'(1'b1));
        check({tag, " latency"}, 32'(edges), 32'(lat_exp));
        check({tag, " res"},  d1 ? res1 : res0, e.res);
        check({tag, " cry"},  32'(d1 ? ocry1 : ocry0),   32'(e.cry));
        check({tag, " ovf"},  32'(d1 ? oovf1 : oovf0),   32'(e.ovf));
        check({tag, " zero"}, 32'(d1 ? ozero1 : ozero0), 32'(e.zero));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t        exp_q[$];
        exp_t        e;
        int          sent, got, stale;
        logic [31:0] held_res;
        logic [31:0] na, nb;
        logic        ncy, nsub;

        rst_n  = 1'b0;
        valid0 = 1'b0; a0 = '0; b0 = '0; cry0 = 1'b0; sub0 = 1'b0; rdy0 = 1'b1;
        valid1 = 1'b0; a1 = '0; b1 = '0; cry1 = 1'b0; sub1 = 1'b0; rdy1 = 1'b1;
        #1;
        // Reset state
        check("rst o_valid", 32'(ovld0),  32'(1'b0));
        check("rst o_res",   res0,        32'h0);
        check("rst o_cry",   32'(ocry0),  32'(1'b0));
        check("rst o_ovf",   32'(oovf0),  32'(1'b0));
        check("rst o_zero",  32'(ozero0), 32'(1'b0));
        check("rst o_ready", 32'(ordy0),  32'(1'b1));
        check("rst1 o_valid", 32'(ovld1), 32'(1'b0));
        check("rst1 o_ready", 32'(ordy1), 32'(1'b1));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_single(1'b0, "carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_single(1'b0, "signed_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_single(1'b0, "sub_borrow",  32'd5,         32'd7,         1'b1, 1'b1);
        run_single(1'b0, "add_cin",     32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
        run_single(1'b1, "one_stage",   32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        run_single(1'b1, "one_stage_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

        // Random isolated operations on both instances
        for (int i = 0; i < 4; i++) begin
            run_single(1'b0, "rand4", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_single(1'b1, "rand1", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream: three ops in flight, the oldest already at the output
        for (int i = 0; i < 3; i++) begin
            valid0 = 1'b1; a0 = $urandom; b0 = $urandom; cry0 = 1'b0; sub0 = 1'b0;
            @(posedge clk); #1;
        end
        valid0 = 1'b0;
        @(posedge clk); #1;
        check("pre-reset o_valid", 32'(ovld0), 32'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset o_valid", 32'(ovld0),  32'(1'b0));
        check("mid-reset o_res",   res0,        32'h0);
        check("mid-reset o_cry",   32'(ocry0),  32'(1'b0));
        check("mid-reset o_ovf",   32'(oovf0),  32'(1'b0));
        check("mid-reset o_zero",  32'(ozero0), 32'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ovld0) stale++;
        end
        check("post-reset stale results", 32'(stale), 32'd0);

        // Back-to-back stream of 8 random ops with a 3-cycle output stall
        sent = 0; got = 0; held_res = '0;
        na = $urandom; nb = $urandom; ncy = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            valid0 = (sent < 8);
            a0 = na; b0 = nb; cry0 = ncy; sub0 = nsub;
            rdy0 = !(cyc >= 6 && cyc < 9);
            #1;
            if (!rdy0) check("stall o_ready", 32'(ordy0), 32'(1'b0));
            if (cyc == 6) begin
                check("stall o_valid", 32'(ovld0), 32'(1'b1));
                held_res = res0;
            end
            if (cyc >= 7 && cyc <= 9) begin
                check("stall held o_valid", 32'(ovld0), 32'(1'b1));
                check("stall held o_res",   res0, held_res);
            end
            if (ovld0 && rdy0) begin
                if (exp_q.size() == 0) begin
                    check("stream extra result", 32'(ovld0), 32'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check("stream res",  res0,          e.res);
                    check("stream cry",  32'(ocry0),   32'(e.cry));
                    check("stream ovf",  32'(oovf0),   32'(e.ovf));
                    check("stream zero", 32'(ozero0),  32'(e.zero));
                    got++;
                end
            end
            if (valid0 && ordy0) begin
                exp_q.push_back(model(na, nb, ncy, nsub));
                sent++;
                na = $urandom; nb = $urandom; ncy = 1'($urandom_range(0, 1)); nsub = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        valid0 = 1'b0; rdy0 = 1'b1;
        check("stream results received", 32'(got), 32'd8);
        check("stream leftover expected", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
